burst_sequencer: RTL and testbench

//   Sits downstream of the pulse-synchronizer stage in the sync_clk domain.

---
 rtl/burst_sequencer.sv | 152 +++++++++++++++
 tb/tb_burst_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_sequencer.sv
// Programmable pulse-burst generator. Each accepted start pulse emits N pulses
// of H cycles high separated by L cycles low, then strobes done for one cycle.
module burst_sequencer #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
) (
   input  logic             sync_clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [NUM_W-1:0] num_pulses,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulse_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

   state_t           state_q;
   logic [NUM_W-1:0] n_q;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] l_q;
   logic [CNT_W-1:0] cnt_q;
   logic [NUM_W-1:0] pulse_count_q;
   logic             pulse_out_q;
   logic             busy_q;
   logic             done_q;

   logic [CNT_W-1:0] h_d;
   logic [CNT_W-1:0] l_d;

   // Zero widths are promoted to one cycle so every phase is observable.
   always_comb begin
      h_d = high_cycles;
      l_d = low_cycles;
      if (high_cycles == {CNT_W{1'b0}}) begin
         h_d = CNT_ONE;
      end else begin
         h_d = high_cycles;
      end
      if (low_cycles == {CNT_W{1'b0}}) begin
         l_d = CNT_ONE;
      end else begin
         l_d = low_cycles;
      end
   end

   // cnt_q counts cycles already spent in the current phase, including this one.
   always_ff @(posedge sync_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         n_q           <= {NUM_W{1'b0}};
         h_q           <= {CNT_W{1'b0}};
         l_q           <= {CNT_W{1'b0}};
         cnt_q         <= {CNT_W{1'b0}};
         pulse_count_q <= {NUM_W{1'b0}};
         pulse_out_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q      <= 1'b0;
               pulse_out_q <= 1'b0;
               busy_q      <= 1'b0;
               if (start && !abort) begin
                  n_q   <= num_pulses;
                  h_q   <= h_d;
                  l_q   <= l_d;
                  cnt_q <= CNT_ONE;
                  if (num_pulses != {NUM_W{1'b0}}) begin
                     state_q       <= HIGH;
                     pulse_out_q   <= 1'b1;
                     busy_q        <= 1'b1;
                     pulse_count_q <= NUM_ONE;
                  end else begin
                     state_q       <= DONE;
                     done_q        <= 1'b1;
                     pulse_count_q <= {NUM_W{1'b0}};
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            HIGH: begin
               if (abort) begin
                  state_q     <= IDLE;
                  pulse_out_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b0;
               end else if (cnt_q == h_q) begin
                  pulse_out_q <= 1'b0;
                  cnt_q       <= CNT_ONE;
                  if (pulse_count_q == n_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= LOW;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            LOW: begin
               if (abort) begin
                  state_q     <= IDLE;
                  pulse_out_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b0;
               end else if (cnt_q == l_q) begin
                  state_q       <= HIGH;
                  pulse_out_q   <= 1'b1;
                  cnt_q         <= CNT_ONE;
                  pulse_count_q <= pulse_count_q + NUM_ONE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               pulse_out_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               pulse_out_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_out   = pulse_out_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer: per-cycle vector table plus hand-written
// sequences for reset, abort and the maximum pulse count.
module tb_burst_sequencer;

   logic        sync_clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [7:0]  num_pulses;
   logic [15:0] high_cycles;
   logic [15:0] low_cycles;
   logic        pulse_out;
   logic        busy;
   logic        done;
   logic [7:0]  pulse_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        st;
      logic        ab;
      logic [7:0]  n;
      logic [15:0] h;
      logic [15:0] l;
      logic        p;
      logic        b;
      logic        d;
      logic [7:0]  c;
   } vec_t;

   vec_t vecs[$];

   burst_sequencer #(.CNT_W(16), .NUM_W(8)) dut (
      .sync_clk    (sync_clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .num_pulses  (num_pulses),
      .high_cycles (high_cycles),
      .low_cycles  (low_cycles),
      .pulse_out   (pulse_out),
      .busy        (busy),
      .done        (done),
      .pulse_count (pulse_count)
   );

   initial sync_clk = 1'b0;
   always #5 sync_clk = ~sync_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sync_clk);
      #1;
   endtask

   task automatic add(input logic st, input logic ab, input logic [7:0] n,
                      input logic [15:0] h, input logic [15:0] l,
                      input logic p, input logic b, input logic d, input logic [7:0] c);
      vec_t v;
      v.st = st; v.ab = ab; v.n = n; v.h = h; v.l = l;
      v.p = p; v.b = b; v.d = d; v.c = c;
      vecs.push_back(v);
   endtask

   task automatic set_in(input logic st, input logic ab, input logic [7:0] n,
                         input logic [15:0] h, input logic [15:0] l);
      start = st; abort = ab; num_pulses = n; high_cycles = h; low_cycles = l;
   endtask

   int cyc;
   int rises;
   logic prev;

   initial begin
      // Row: inputs for cycle c, then expected outputs in cycle c+1.
      // N=3 H=2 L=3 with ignored starts mid-burst, in DONE, and start+abort in IDLE.
      add(1, 0, 3, 2, 3,  1, 1, 0, 1);
      add(0, 0, 3, 2, 3,  1, 1, 0, 1);
      add(0, 0, 3, 2, 3,  0, 1, 0, 1);
      add(0, 0, 3, 2, 3,  0, 1, 0, 1);
      add(1, 0, 9, 7, 7,  0, 1, 0, 1);
      add(0, 0, 9, 7, 7,  1, 1, 0, 2);
      add(1, 0, 9, 7, 7,  1, 1, 0, 2);
      add(0, 0, 3, 2, 3,  0, 1, 0, 2);
      add(0, 0, 3, 2, 3,  0, 1, 0, 2);
      add(0, 0, 3, 2, 3,  0, 1, 0, 2);
      add(0, 0, 3, 2, 3,  1, 1, 0, 3);
      add(0, 0, 3, 2, 3,  1, 1, 0, 3);
      add(0, 0, 3, 2, 3,  0, 0, 1, 3);
      add(1, 0, 9, 7, 7,  0, 0, 0, 3);
      add(1, 1, 5, 1, 1,  0, 0, 0, 3);
      add(0, 0, 5, 1, 1,  0, 0, 0, 3);
      // N=0: done next cycle, count cleared.
      add(1, 0, 0, 4, 4,  0, 0, 1, 0);
      add(0, 0, 0, 4, 4,  0, 0, 0, 0);
      add(0, 0, 0, 4, 4,  0, 0, 0, 0);
      // N=2 with H=L=0 behaves as H=L=1.
      add(1, 0, 2, 0, 0,  1, 1, 0, 1);
      add(0, 0, 2, 0, 0,  0, 1, 0, 1);
      add(0, 0, 2, 0, 0,  1, 1, 0, 2);
      add(0, 0, 2, 0, 0,  0, 0, 1, 2);
      add(0, 0, 2, 0, 0,  0, 0, 0, 2);

      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0);
      tick(); tick();
      chk("reset pulse_out", {31'd0, pulse_out}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset pulse_count", {24'd0, pulse_count}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Asynchronous reset in the middle of a burst.
      set_in(1, 0, 3, 2, 3);
      tick();
      set_in(0, 0, 3, 2, 3);
      tick();
      chk("pre-reset pulse_out", {31'd0, pulse_out}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async rst pulse_out", {31'd0, pulse_out}, 32'd0);
      chk("async rst busy", {31'd0, busy}, 32'd0);
      chk("async rst done", {31'd0, done}, 32'd0);
      chk("async rst pulse_count", {24'd0, pulse_count}, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("post-reset idle pulse_out %0d", i), {31'd0, pulse_out}, 32'd0);
         chk($sformatf("post-reset idle busy %0d", i), {31'd0, busy}, 32'd0);
         chk($sformatf("post-reset idle done %0d", i), {31'd0, done}, 32'd0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].st, vecs[i].ab, vecs[i].n, vecs[i].h, vecs[i].l);
         tick();
         chk($sformatf("vec %0d pulse_out", i), {31'd0, pulse_out}, {31'd0, vecs[i].p});
         chk($sformatf("vec %0d busy", i), {31'd0, busy}, {31'd0, vecs[i].b});
         chk($sformatf("vec %0d done", i), {31'd0, done}, {31'd0, vecs[i].d});
         chk($sformatf("vec %0d pulse_count", i), {24'd0, pulse_count}, {24'd0, vecs[i].c});
      end

      // Abort on the 3rd LOW cycle after pulse 2 (N=4, H=L=5): cycle 18.
      set_in(1, 0, 4, 5, 5);
      tick();
      cyc = 1;
      set_in(0, 0, 4, 5, 5);
      while (cyc < 18) begin
         tick();
         cyc++;
      end
      chk("abort pre busy", {31'd0, busy}, 32'd1);
      chk("abort pre pulse_out", {31'd0, pulse_out}, 32'd0);
      chk("abort pre pulse_count", {24'd0, pulse_count}, 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort pulse_out", {31'd0, pulse_out}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort pulse_count", {24'd0, pulse_count}, 32'd2);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("after abort no done %0d", i), {30'd0, done, pulse_out}, 32'd0);
      end
      set_in(1, 0, 1, 1, 1);
      tick();
      set_in(0, 0, 1, 1, 1);
      chk("restart pulse_out", {31'd0, pulse_out}, 32'd1);
      chk("restart pulse_count", {24'd0, pulse_count}, 32'd1);
      tick();
      chk("restart done", {31'd0, done}, 32'd1);
      chk("restart busy", {31'd0, busy}, 32'd0);
      tick();

      // Maximum pulse count: N=255, H=L=1 -> done in cycle 255+254+1.
      set_in(1, 0, 8'd255, 1, 1);
      tick();
      set_in(0, 0, 8'd255, 1, 1);
      cyc = 1;
      rises = pulse_out ? 1 : 0;
      prev = pulse_out;
      while (!done && cyc < 2000) begin
         tick();
         cyc++;
         if (pulse_out && !prev) rises++;
         prev = pulse_out;
      end
      chk("maxN done cycle", cyc, 32'd510);
      chk("maxN pulse rises", rises, 32'd255);
      chk("maxN pulse_count", {24'd0, pulse_count}, 32'd255);
      chk("maxN busy at done", {31'd0, busy}, 32'd0);
      tick();
      chk("maxN count holds", {24'd0, pulse_count}, 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
